// File: rtl/sd_err_pkg.sv
// Shared constants for the SD Host error interrupt block: bit indices, group masks, recovery states.
package sd_err_pkg;

  localparam int ERR_WIDTH = 16;

  localparam int ERR_CMD_TO     = 0;
  localparam int ERR_CMD_CRC    = 1;
  localparam int ERR_CMD_END    = 2;
  localparam int ERR_CMD_IDX    = 3;
  localparam int ERR_DAT_TO     = 4;
  localparam int ERR_DAT_CRC    = 5;
  localparam int ERR_DAT_END    = 6;
  localparam int ERR_CUR_LIM    = 7;
  localparam int ERR_ACMD12     = 8;
  localparam int ERR_ADMA       = 9;
  localparam int ERR_VENDOR_LSB = 12;

  localparam logic [15:0] CMD_MASK   = 16'h000F;
  localparam logic [15:0] DAT_MASK   = 16'h0270;
  localparam logic [15:0] RSVD_MASK  = 16'h0C00;
  // Bits the host must clear before recovery is re-armed.
  localparam logic [15:0] RECOV_MASK = CMD_MASK | DAT_MASK;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD_RST  = 2'd1,
    DAT_RST  = 2'd2,
    WAIT_CLR = 2'd3
  } recov_state_t;

  function automatic logic group_hit(input logic [15:0] vec, input logic [15:0] mask);
    return |(vec & mask);
  endfunction

endpackage

// File: rtl/err_int_ctrl_if.sv
// Signal bundle between the error sources / register file (master) and err_int_ctrl (slave).
// Optional Force Event signals appear when ERR_FORCE_EN is defined.
interface err_int_ctrl_if;
  import sd_err_pkg::*;

  logic [15:0]  err_evt;
  logic [15:0]  stat_en;
  logic [15:0]  sig_en;
  logic         wr_stb;
  logic [15:0]  wr_data;
  logic         cmd_rst_ack;
  logic         dat_rst_ack;
`ifdef ERR_FORCE_EN
  logic         force_stb;
  logic [15:0]  force_data;
`endif
  logic [15:0]  err_status;
  logic         err_int;
  logic         cmd_rst_req;
  logic         dat_rst_req;
  logic         recov_busy;
  recov_state_t recov_state;

  // Reset handshake: a req stays high until its ack level is sampled high (or the wait
  // times out); the req drops the cycle after, and only one req is ever high at a time.
  modport master (
`ifdef ERR_FORCE_EN
    output force_stb, force_data,
`endif
    output err_evt, stat_en, sig_en, wr_stb, wr_data, cmd_rst_ack, dat_rst_ack,
    input  err_status, err_int, cmd_rst_req, dat_rst_req, recov_busy, recov_state
  );

  modport slave (
`ifdef ERR_FORCE_EN
    input  force_stb, force_data,
`endif
    input  err_evt, stat_en, sig_en, wr_stb, wr_data, cmd_rst_ack, dat_rst_ack,
    output err_status, err_int, cmd_rst_req, dat_rst_req, recov_busy, recov_state
  );

endinterface

// File: rtl/err_recov_fsm.sv
// CMD/DAT line recovery sequencer: pending flags, reset req/ack handshakes and ack timeout.
module err_recov_fsm
  import sd_err_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  evt,
  input  logic [15:0]  status,
  input  logic         cmd_rst_ack,
  input  logic         dat_rst_ack,
  output logic         cmd_rst_req,
  output logic         dat_rst_req,
  output logic         timeout,
  output logic         busy,
  output recov_state_t state
);

  localparam int             CW       = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] cnt;
  logic          cmd_pend;
  logic          dat_pend;
  logic          in_rst;
  logic          ack;
  logic          step_done;
  logic          cmd_hit;
  logic          dat_hit;

  assign cmd_hit   = group_hit(evt, CMD_MASK);
  assign dat_hit   = group_hit(evt, DAT_MASK);
  assign in_rst    = (state == CMD_RST) || (state == DAT_RST);
  assign ack       = ((state == CMD_RST) && cmd_rst_ack) || ((state == DAT_RST) && dat_rst_ack);
  // An ack arriving on the last counted cycle still counts as an ack, not a timeout.
  assign timeout   = in_rst && !ack && (cnt == CNT_LAST);
  assign step_done = ack || timeout;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_rst_req <= 1'b0;
      dat_rst_req <= 1'b0;
      cnt         <= '0;
      cmd_pend    <= 1'b0;
      dat_pend    <= 1'b0;
    end else begin
      // A new event on the same edge as completion re-arms the flag.
      cmd_pend <= (cmd_pend && !(step_done && state == CMD_RST)) || cmd_hit;
      dat_pend <= (dat_pend && !(step_done && state == DAT_RST)) || dat_hit;

      case (state)
        IDLE: begin
          if (cmd_pend) begin
            state       <= CMD_RST;
            cmd_rst_req <= 1'b1;
            cnt         <= '0;
          end else if (dat_pend) begin
            state       <= DAT_RST;
            dat_rst_req <= 1'b1;
            cnt         <= '0;
          end
        end
        CMD_RST: begin
          if (step_done) begin
            cmd_rst_req <= 1'b0;
            if (dat_pend) begin
              state       <= DAT_RST;
              dat_rst_req <= 1'b1;
              cnt         <= '0;
            end else begin
              state <= WAIT_CLR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DAT_RST: begin
          if (step_done) begin
            dat_rst_req <= 1'b0;
            if (cmd_pend) begin
              state       <= CMD_RST;
              cmd_rst_req <= 1'b1;
              cnt         <= '0;
            end else begin
              state <= WAIT_CLR;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_CLR: begin
          if ((status & RECOV_MASK) == 16'h0000) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/err_int_ctrl.sv
// Error Interrupt Status (032h) with W1C, status/signal enables and line-reset recovery.
// Define ERR_FORCE_EN to add the Force Event register inputs as a second set source.
module err_int_ctrl
  import sd_err_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  err_int_ctrl_if.slave bus
);

  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic             int_q;
  logic             timeout;

  always_comb begin
    set_vec = bus.err_evt;
`ifdef ERR_FORCE_EN
    if (bus.force_stb) set_vec = set_vec | bus.force_data;
`endif
  end

  assign clr_vec = bus.wr_stb ? bus.wr_data : '0;

  // Set beats clear; disabled and reserved bits are forced to zero.
  always_comb begin
    status_d = (status_q & ~clr_vec) | set_vec;
    if (timeout) status_d[ERR_VENDOR_LSB] = 1'b1;
    status_d = status_d & bus.stat_en & ~RSVD_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      int_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      int_q    <= |(status_q & bus.sig_en);
    end
  end

  err_recov_fsm #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_recov (
    .clk         (clk),
    .rst         (rst),
    .evt         (set_vec & bus.stat_en),
    .status      (status_q),
    .cmd_rst_ack (bus.cmd_rst_ack),
    .dat_rst_ack (bus.dat_rst_ack),
    .cmd_rst_req (bus.cmd_rst_req),
    .dat_rst_req (bus.dat_rst_req),
    .timeout     (timeout),
    .busy        (bus.recov_busy),
    .state       (bus.recov_state)
  );

  assign bus.err_status = status_q;
  assign bus.err_int    = int_q;

endmodule

// File: tb/tb_err_int_ctrl.sv
// Bench for err_int_ctrl: cycle model of the status/IRQ/recovery rules plus directed checks.
module tb_err_int_ctrl;
  import sd_err_pkg::*;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  err_int_ctrl_if bus();

  err_int_ctrl #(
    .WIDTH       (16),
    .ACK_TIMEOUT (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: active reset (0 none, 1 cmd, 2 dat), cycles its req has been high, waiting-for-clear flag.
  logic [15:0] m_status = 16'h0;
  logic        m_int    = 1'b0;
  int          m_active = 0;
  int          m_age    = 0;
  logic        m_wait   = 1'b0;
  logic        m_cp     = 1'b0;
  logic        m_dp     = 1'b0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_status = 16'h0; m_int = 1'b0; m_active = 0; m_age = 0;
    m_wait = 1'b0; m_cp = 1'b0; m_dp = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_update();
    logic [15:0] set;
    logic [15:0] nxt;
    logic        done;
    logic        to;
    logic        ack;
    logic        ncp;
    logic        ndp;
    int          old_active;
    done = 1'b0;
    to   = 1'b0;
    old_active = m_active;
    if (m_active != 0) begin
      ack = (m_active == 1) ? bus.cmd_rst_ack : bus.dat_rst_ack;
      if (ack) done = 1'b1;
      else if (m_age == T) begin done = 1'b1; to = 1'b1; end
      else m_age++;
    end
    set = bus.err_evt;
`ifdef ERR_FORCE_EN
    if (bus.force_stb) set = set | bus.force_data;
`endif
    set = set & bus.stat_en;
    nxt = m_status;
    if (bus.wr_stb) nxt = nxt & ~bus.wr_data;
    nxt = (nxt | set | (to ? 16'h1000 : 16'h0000)) & bus.stat_en & 16'hF3FF;
    m_int = |(m_status & bus.sig_en);
    ncp = (m_cp && !(done && old_active == 1)) || ((set & 16'h000F) != 0);
    ndp = (m_dp && !(done && old_active == 2)) || ((set & 16'h0270) != 0);
    if (m_active == 0 && !m_wait) begin
      if (m_cp) begin m_active = 1; m_age = 1; end
      else if (m_dp) begin m_active = 2; m_age = 1; end
    end else if (m_active != 0) begin
      if (done) begin
        if (old_active == 1 && m_dp) begin m_active = 2; m_age = 1; end
        else if (old_active == 2 && m_cp) begin m_active = 1; m_age = 1; end
        else begin m_active = 0; m_wait = 1'b1; end
      end
    end else if ((m_status & 16'h027F) == 16'h0) begin
      m_wait = 1'b0;
    end
    m_cp = ncp;
    m_dp = ndp;
    m_status = nxt;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      model_update();
      exp_q.push_back(m_status);
    end
    @(negedge clk);
  endtask

  task automatic tick(input logic [15:0] evt, input logic wr, input logic [15:0] wd);
    bus.err_evt = evt;
    bus.wr_stb  = wr;
    bus.wr_data = wd;
    step();
    bus.err_evt = 16'h0;
    bus.wr_stb  = 1'b0;
    bus.wr_data = 16'h0;
  endtask

  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      chk("cyc_status", 32'(bus.err_status), 32'(exp_q.pop_front()));
      chk("cyc_int", 32'(bus.err_int), 32'(m_int));
      chk("cyc_cmd_req", 32'(bus.cmd_rst_req), 32'(m_active == 1));
      chk("cyc_dat_req", 32'(bus.dat_rst_req), 32'(m_active == 2));
      chk("cyc_busy", 32'(bus.recov_busy), 32'(m_active != 0 || m_wait));
    end
  end

  initial begin
    bus.err_evt = 16'h0; bus.stat_en = 16'hFFFF; bus.sig_en = 16'hFFFF;
    bus.wr_stb = 1'b0; bus.wr_data = 16'h0;
    bus.cmd_rst_ack = 1'b0; bus.dat_rst_ack = 1'b0;
`ifdef ERR_FORCE_EN
    bus.force_stb = 1'b0; bus.force_data = 16'h0;
`endif
    step(); step();
    chk("rst_status", 32'(bus.err_status), 32'h0);
    chk("rst_int", 32'(bus.err_int), 32'h0);
    chk("rst_busy", 32'(bus.recov_busy), 32'h0);
    rst = 1'b0;
    step();

    // 1: CMD CRC pulse, latency and ack handshake
    tick(16'h0002, 1'b0, 16'h0);
    chk("t1_status", 32'(bus.err_status), 32'h0002);
    chk("t1_int_early", 32'(bus.err_int), 32'h0);
    step();
    chk("t1_int", 32'(bus.err_int), 32'h1);
    chk("t1_cmd_req", 32'(bus.cmd_rst_req), 32'h1);
    step(); step();
    bus.cmd_rst_ack = 1'b1;
    step();
    chk("t1_req_drop", 32'(bus.cmd_rst_req), 32'h0);
    chk("t1_state", 32'(bus.recov_state), 32'(WAIT_CLR));
    bus.cmd_rst_ack = 1'b0;
    tick(16'h0, 1'b1, 16'hFFFF);
    chk("t1_clr", 32'(bus.err_status), 32'h0);
    step();
    chk("t1_idle", 32'(bus.recov_busy), 32'h0);

    // 2: set wins over same-cycle clear
    bus.dat_rst_ack = 1'b1;
    tick(16'h0020, 1'b0, 16'h0);
    chk("t2_set", 32'(bus.err_status), 32'h0020);
    tick(16'h0020, 1'b1, 16'h0020);
    chk("t2_set_wins", 32'(bus.err_status), 32'h0020);
    tick(16'h0, 1'b1, 16'h0020);
    chk("t2_clear", 32'(bus.err_status), 32'h0);
    step();
    chk("t2_int_low", 32'(bus.err_int), 32'h0);
    step(); step();
    bus.dat_rst_ack = 1'b0;

    // 3: CMD then DAT recovery
    bus.cmd_rst_ack = 1'b1; bus.dat_rst_ack = 1'b1;
    tick(16'h0011, 1'b0, 16'h0);
    chk("t3_status", 32'(bus.err_status), 32'h0011);
    step();
    chk("t3_cmd_req", 32'(bus.cmd_rst_req), 32'h1);
    step();
    chk("t3_dat_req", 32'(bus.dat_rst_req), 32'h1);
    chk("t3_cmd_low", 32'(bus.cmd_rst_req), 32'h0);
    step();
    chk("t3_state", 32'(bus.recov_state), 32'(WAIT_CLR));
    tick(16'h0, 1'b1, 16'hFFFF);
    step();
    chk("t3_idle", 32'(bus.recov_busy), 32'h0);
    bus.cmd_rst_ack = 1'b0; bus.dat_rst_ack = 1'b0;

    // 4: DAT ack timeout
    tick(16'h0040, 1'b0, 16'h0);
    step();
    chk("t4_req", 32'(bus.dat_rst_req), 32'h1);
    repeat (T - 1) step();
    chk("t4_req_hold", 32'(bus.dat_rst_req), 32'h1);
    step();
    chk("t4_status", 32'(bus.err_status), 32'h1040);
    chk("t4_req_drop", 32'(bus.dat_rst_req), 32'h0);
    chk("t4_state", 32'(bus.recov_state), 32'(WAIT_CLR));
    tick(16'h0, 1'b1, 16'hFFFF);
    step();

    // 5: status enable off, then reset mid-handshake
    bus.stat_en = 16'h0000;
    tick(16'hFFFF, 1'b0, 16'h0);
    chk("t5_status", 32'(bus.err_status), 32'h0);
    step();
    chk("t5_int", 32'(bus.err_int), 32'h0);
    chk("t5_no_req", 32'({bus.cmd_rst_req, bus.dat_rst_req}), 32'h0);
    bus.stat_en = 16'hFFFF;
    tick(16'h0001, 1'b0, 16'h0);
    step();
    chk("t5_in_cmd", 32'(bus.cmd_rst_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_rst_status", 32'(bus.err_status), 32'h0);
    chk("t5_rst_int", 32'(bus.err_int), 32'h0);
    chk("t5_rst_req", 32'({bus.cmd_rst_req, bus.dat_rst_req}), 32'h0);
    chk("t5_rst_busy", 32'(bus.recov_busy), 32'h0);
    model_reset();
    step();
    rst = 1'b0;
    step();

    // 6: signal enable masks the interrupt
    bus.sig_en = 16'h0000;
    tick(16'h0001, 1'b0, 16'h0);
    chk("t6_status", 32'(bus.err_status), 32'h0001);
    step();
    chk("t6_int", 32'(bus.err_int), 32'h0);
    bus.cmd_rst_ack = 1'b1;
    step(); step();
    tick(16'h0, 1'b1, 16'hFFFF);
    step();
    bus.cmd_rst_ack = 1'b0;
    bus.sig_en = 16'hFFFF;
`ifdef ERR_FORCE_EN
    bus.force_stb = 1'b1; bus.force_data = 16'h0100;
    step();
    bus.force_stb = 1'b0; bus.force_data = 16'h0;
    chk("t6_force", 32'(bus.err_status), 32'h0100);
    step(); step();
    chk("t6_force_noreq", 32'({bus.cmd_rst_req, bus.dat_rst_req}), 32'h0);
    chk("t6_force_idle", 32'(bus.recov_busy), 32'h0);
`endif
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
